// File: rtl/pll_seq_pkg.sv
// Shared state encoding, output widths and sizing helper for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_state_e;

  localparam int unsigned LOSS_W    = 8;
  localparam int unsigned ATTEMPT_W = 2;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-high reset to zero.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer: holds the PLL in reset, waits for lock with timeout and retry,
// and releases the system reset only after lock has been stable. Optional: PLL_LOSS_COUNT_EN.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned PLL_RESET_CYCLES = 4,
  parameter int unsigned LOCK_TIMEOUT     = 65536,
  parameter int unsigned STABLE_CYCLES    = 1024,
  parameter int unsigned MAX_RETRIES      = 3
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 pll_locked_i,
  input  logic                 restart_i,
  output logic                 pll_resetb_o,
  output logic                 sys_reset_o,
  output logic                 ready_o,
  output logic                 fault_o,
  output logic [ATTEMPT_W-1:0] attempt_o,
  output logic [LOSS_W-1:0]    loss_count_o
);

  localparam int unsigned CNT_MAX = max3(PLL_RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);

  pll_state_e           state_q, state_nxt;
  logic [CNT_W-1:0]     cnt_q, cnt_nxt;
  logic [RETRY_W-1:0]   retry_q, retry_nxt;
  logic                 lock_s;
  logic                 pll_resetb_nxt, sys_reset_nxt, ready_nxt, fault_nxt;
  logic [ATTEMPT_W-1:0] attempt_nxt;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .d      (pll_locked_i),
    .q      (lock_s)
  );

  // State, counter and output registers; outputs are the decode of the next state.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= PLL_RST;
      cnt_q        <= '0;
      retry_q      <= '0;
      pll_resetb_o <= 1'b0;
      sys_reset_o  <= 1'b1;
      ready_o      <= 1'b0;
      fault_o      <= 1'b0;
      attempt_o    <= '0;
    end else begin
      state_q      <= state_nxt;
      cnt_q        <= cnt_nxt;
      retry_q      <= retry_nxt;
      pll_resetb_o <= pll_resetb_nxt;
      sys_reset_o  <= sys_reset_nxt;
      ready_o      <= ready_nxt;
      fault_o      <= fault_nxt;
      attempt_o    <= attempt_nxt;
    end
  end

  // Next-state logic; restart_i overrides every other transition.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q + CNT_W'(1);
    retry_nxt = retry_q;

    if (restart_i) begin
      state_nxt = PLL_RST;
      retry_nxt = '0;
    end else begin
      case (state_q)
        PLL_RST: begin
          if (cnt_q == CNT_W'(PLL_RESET_CYCLES - 1)) state_nxt = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_nxt = STABLE;
          end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
            if (retry_q == RETRY_W'(MAX_RETRIES - 1)) begin
              state_nxt = FAULT;
            end else begin
              retry_nxt = retry_q + RETRY_W'(1);
              state_nxt = PLL_RST;
            end
          end
        end
        STABLE: begin
          if (!lock_s) state_nxt = WAIT_LOCK;
          else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) state_nxt = RUN;
        end
        RUN: begin
          if (!lock_s) begin
            state_nxt = PLL_RST;
            retry_nxt = '0;
          end
        end
        FAULT:   state_nxt = FAULT;
        default: state_nxt = PLL_RST;
      endcase
    end

    // The single counter restarts on any state change and idles in RUN/FAULT.
    if (restart_i || (state_nxt != state_q) || (state_q == RUN) || (state_q == FAULT)) begin
      cnt_nxt = '0;
    end

    pll_resetb_nxt = (state_nxt != PLL_RST) && (state_nxt != FAULT);
    sys_reset_nxt  = (state_nxt != RUN);
    ready_nxt      = (state_nxt == RUN);
    fault_nxt      = (state_nxt == FAULT);
    attempt_nxt    = (32'(retry_nxt) > 32'd3) ? ATTEMPT_W'(3) : ATTEMPT_W'(retry_nxt);
  end

`ifdef PLL_LOSS_COUNT_EN
  logic              loss_evt_c;
  logic [LOSS_W-1:0] loss_q;

  assign loss_evt_c = (state_q == RUN) && !lock_s && !restart_i;

  // Saturating lock-loss counter; only reset_i clears it.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      loss_q <= '0;
    end else if (loss_evt_c && (loss_q != '1)) begin
      loss_q <= loss_q + LOSS_W'(1);
    end
  end

  assign loss_count_o = loss_q;
`else
  assign loss_count_o = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: table-driven cycle vectors through a
// scoreboard queue, plus hand-written sequences for async reset, lock loss and fault.
module tb_pll_reset_sequencer;

  localparam int unsigned N_LOSS = 300;

  typedef struct packed {
    logic       resetb;
    logic       sys;
    logic       ready;
    logic       fault;
    logic [1:0] att;
    logic [7:0] loss;
  } out_t;

  // ctl = {lock, restart, resetb, sys_reset, ready, fault}
  typedef struct {
    int         n;
    logic [5:0] ctl;
    logic [1:0] att;
    logic [7:0] loss;
  } vec_t;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       pll_locked_i;
  logic       restart_i;
  logic       pll_resetb_o;
  logic       sys_reset_o;
  logic       ready_o;
  logic       fault_o;
  logic [1:0] attempt_o;
  logic [7:0] loss_count_o;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  vec_t vq[$];
  out_t sb_q[$];

  pll_reset_sequencer #(
    .PLL_RESET_CYCLES(4),
    .LOCK_TIMEOUT    (16),
    .STABLE_CYCLES   (8),
    .MAX_RETRIES     (3)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .pll_locked_i(pll_locked_i),
    .restart_i   (restart_i),
    .pll_resetb_o(pll_resetb_o),
    .sys_reset_o (sys_reset_o),
    .ready_o     (ready_o),
    .fault_o     (fault_o),
    .attempt_o   (attempt_o),
    .loss_count_o(loss_count_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int exp_loss(input int n);
`ifdef PLL_LOSS_COUNT_EN
    return (n > 255) ? 255 : n;
`else
    return 0 * n;
`endif
  endfunction

  function automatic out_t mk_exp(input vec_t v);
    out_t e;
    e.resetb = v.ctl[3];
    e.sys    = v.ctl[2];
    e.ready  = v.ctl[1];
    e.fault  = v.ctl[0];
    e.att    = v.att;
    e.loss   = 8'(exp_loss(int'(v.loss)));
    return e;
  endfunction

  function automatic out_t get_out();
    out_t o;
    o = {pll_resetb_o, sys_reset_o, ready_o, fault_o, attempt_o, loss_count_o};
    return o;
  endfunction

  task automatic add(input int n, input logic [5:0] ctl, input logic [1:0] att,
                     input logic [7:0] loss);
    vec_t v;
    v.n = n; v.ctl = ctl; v.att = att; v.loss = loss;
    vq.push_back(v);
  endtask

  task automatic check_out(input string name, input out_t act, input out_t exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s cycle %0d: got rb=%b sys=%b rdy=%b flt=%b att=%0d loss=%0d, expected rb=%b sys=%b rdy=%b flt=%b att=%0d loss=%0d",
               name, cyc, act.resetb, act.sys, act.ready, act.fault, act.att, act.loss,
               exp.resetb, exp.sys, exp.ready, exp.fault, exp.att, exp.loss);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // One clock of table stimulus: drive on the falling edge, compare just after the rising edge.
  task automatic apply(input string name, input vec_t v);
    out_t e;
    @(negedge clk_i);
    pll_locked_i = v.ctl[5];
    restart_i    = v.ctl[4];
    sb_q.push_back(mk_exp(v));
    @(posedge clk_i);
    #1;
    cyc++;
    if (sb_q.size() == 0) begin
      check_int({name, "_sb_empty"}, 0, 1);
    end else begin
      e = sb_q.pop_front();
      check_out(name, get_out(), e);
    end
  endtask

  localparam out_t RST_OUT = {1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0};

  initial begin
    int         c;
    int         lowc;
    int         hi;
    int         n_loss_done;
    logic [1:0] att_at[3];
    out_t       pre;

    reset_i      = 1'b1;
    pll_locked_i = 1'b0;
    restart_i    = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check_out("reset_state", get_out(), RST_OUT);

    // Power-up with lock at cycle 10, lock loss, three failed attempts, FAULT, restart,
    // retry plus glitch in STABLE, second loss, restart at timeout and inside PLL_RST.
    add( 3, 6'b00_0100, 2'd0, 8'd0);
    add( 7, 6'b00_1100, 2'd0, 8'd0);
    add(10, 6'b10_1100, 2'd0, 8'd0);
    add( 5, 6'b10_1010, 2'd0, 8'd0);
    add( 2, 6'b00_1010, 2'd0, 8'd0);
    add( 4, 6'b00_0100, 2'd0, 8'd1);
    add(16, 6'b00_1100, 2'd0, 8'd1);
    add( 4, 6'b00_0100, 2'd1, 8'd1);
    add(16, 6'b00_1100, 2'd1, 8'd1);
    add( 4, 6'b00_0100, 2'd2, 8'd1);
    add(16, 6'b00_1100, 2'd2, 8'd1);
    add( 5, 6'b00_0101, 2'd2, 8'd1);
    add( 1, 6'b01_0100, 2'd0, 8'd1);
    add( 3, 6'b00_0100, 2'd0, 8'd1);
    add(16, 6'b00_1100, 2'd0, 8'd1);
    add( 4, 6'b00_0100, 2'd1, 8'd1);
    add( 1, 6'b00_1100, 2'd1, 8'd1);
    add( 5, 6'b10_1100, 2'd1, 8'd1);
    add( 1, 6'b00_1100, 2'd1, 8'd1);
    add(10, 6'b10_1100, 2'd1, 8'd1);
    add( 4, 6'b10_1010, 2'd1, 8'd1);
    add( 2, 6'b00_1010, 2'd1, 8'd1);
    add( 4, 6'b00_0100, 2'd0, 8'd2);
    add(16, 6'b00_1100, 2'd0, 8'd2);
    add( 1, 6'b01_0100, 2'd0, 8'd2);
    add( 1, 6'b00_0100, 2'd0, 8'd2);
    add( 1, 6'b01_0100, 2'd0, 8'd2);
    add( 3, 6'b00_0100, 2'd0, 8'd2);
    add( 5, 6'b00_1100, 2'd0, 8'd2);

    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    foreach (vq[k]) begin
      for (int j = 0; j < vq[k].n; j++) apply($sformatf("vec%0d", k), vq[k]);
    end

    // Enter STABLE, then assert reset_i between clock edges.
    @(negedge clk_i);
    pll_locked_i = 1'b1;
    repeat (5) @(posedge clk_i);
    #1;
    pre = {1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'(exp_loss(2))};
    check_out("pre_async_reset", get_out(), pre);
    #2;
    reset_i = 1'b1;
    #1;
    check_out("async_reset_mid_stable", get_out(), RST_OUT);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;

    // Repeated lock loss from RUN.
    n_loss_done = 0;
    for (int i = 0; i < N_LOSS; i++) begin
      c = 0;
      while (!ready_o && c < 64) begin
        @(posedge clk_i);
        #1;
        c++;
      end
      if (!ready_o) break;
      @(negedge clk_i);
      pll_locked_i = 1'b0;
      c = 0;
      do begin
        @(posedge clk_i);
        #1;
        c++;
      end while (!sys_reset_o && c < 16);
      if (i == 0) begin
        check_int("loss_to_sys_reset_cycles", c, 3);
        check_int("loss_count_first", 32'(loss_count_o), exp_loss(1));
        lowc = 0;
        while (!pll_resetb_o && lowc < 16) begin
          lowc++;
          @(posedge clk_i);
          #1;
        end
        check_int("resetb_low_after_loss", lowc, 4);
      end
      @(negedge clk_i);
      pll_locked_i = 1'b1;
      n_loss_done++;
    end
    check_int("loss_iterations_reached_run", n_loss_done, N_LOSS);
    check_int("loss_count_saturated", 32'(loss_count_o), exp_loss(N_LOSS));

    // Lock never arrives after reset: three attempts then FAULT at cycle 60.
    @(negedge clk_i);
    pll_locked_i = 1'b0;
    reset_i      = 1'b1;
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    c = 0;
    lowc = 0;
    att_at[0] = 2'd3; att_at[1] = 2'd3; att_at[2] = 2'd3;
    while (!fault_o && c < 200) begin
      @(posedge clk_i);
      #1;
      c++;
      if (!pll_resetb_o && !fault_o) lowc++;
      if (c == 10) att_at[0] = attempt_o;
      if (c == 30) att_at[1] = attempt_o;
      if (c == 50) att_at[2] = attempt_o;
    end
    check_int("fault_latency", c, 60);
    check_int("resetb_low_cycles_before_fault", lowc, 11);
    check_int("attempt_first", 32'(att_at[0]), 0);
    check_int("attempt_second", 32'(att_at[1]), 1);
    check_int("attempt_third", 32'(att_at[2]), 2);
    hi = 0;
    repeat (20) begin
      @(posedge clk_i);
      #1;
      if (pll_resetb_o || !fault_o || !sys_reset_o) hi++;
    end
    check_int("fault_hold", hi, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
